serdiv_frontend: RTL
====================

// Module: serdiv_frontend
// PURPOSE
//  Issue/retire wrapper between the execute-stage FU dispatch and serdiv.
//  - Decodes the RV64M divide ops and prepares operands (32-bit word ops sign/zero-extended).
//  - Issues exactly one request into serdiv's in_vld/in_rdy handshake, which has a 1-cycle gap.
//  - Captures serdiv's result, sign-extends word results, and holds it for write-back under valid/ready.
// PARAMETERS
//  XLEN    64                          datapath width; equals serdiv WIDTH
//  TID_W   ariane_pkg::TRANS_ID_BITS   transaction id width
//  PC_W    riscv::VLEN                 pc width (FVT tracking)
// PORTS
//  clk_i          in   1      clock
//  rst_ni         in   1      async reset, active low
//  flush_i        in   1      kill in-flight op
//  in_valid_i     in   1      dispatch request
//  in_ready_o     out  1      frontend can accept
//  op_i           in   3      {word, rem, signed}: 000 DIVU, 001 DIV, 010 REMU, 011 REM, 1xx = *W variants
//  op_a_i         in   XLEN   dividend
//  op_b_i         in   XLEN   divisor
//  trans_id_i     in   TID_W  scoreboard id
//  pc_i           in   PC_W   instruction pc
//  div_vld_o      out  1      serdiv in_vld_i
//  div_rdy_i      in   1      serdiv in_rdy_o
//  div_opcode_o   out  2      serdiv opcode_i = {rem, signed}
//  div_op_a_o     out  XLEN   prepared dividend
//  div_op_b_o     out  XLEN   prepared divisor
//  div_id_o       out  TID_W  serdiv id_i
//  div_pc_o       out  PC_W   serdiv pc_i
//  div_flush_o    out  1      serdiv flush_i; equals flush_i
//  div_out_vld_i  in   1      serdiv out_vld_o
//  div_out_rdy_o  out  1      serdiv out_rdy_i
//  div_id_i       in   TID_W  serdiv id_o
//  div_res_i      in   XLEN   serdiv res_o
//  wb_valid_o     out  1      result valid to write-back
//  wb_ready_i     in   1      write-back accepts
//  wb_trans_id_o  out  TID_W  result id
//  wb_pc_o        out  PC_W   result pc
//  wb_result_o    out  XLEN   final result
// BEHAVIOUR
//  Reset values:
//  - State IDLE; all registers 0.
//  - div_vld_o = div_out_rdy_o = wb_valid_o = 0; in_ready_o = 1.
//  Operand prep, registered on accept:
//  - word & signed:  a = sext(op_a_i[31:0]), b = sext(op_b_i[31:0])
//  - word & !signed: a = zext(op_a_i[31:0]), b = zext(op_b_i[31:0])
//  - !word: operands pass through unchanged.
//  - The word flag is latched. No special-casing of /0 or overflow; serdiv semantics plus word sext
//    give RISC-V results. Example: DIVW 0x80000000 / -1 -> 0xFFFFFFFF80000000.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  - IDLE: in_ready_o=1. On in_valid_i: latch op/operands/id/pc; -> ISSUE.
//  - ISSUE: div_vld_o=1 while div_rdy_i=1; -> WAIT next cycle. If div_rdy_i=0: div_vld_o=0, hold ISSUE.
//    div_vld_o is high for exactly one cycle per op.
//  - WAIT: div_out_rdy_o=1. On div_out_vld_i:
//    - wb_result = word ? sext(div_res_i[31:0]) : div_res_i; latch id/pc; -> RESP.
//    - div_id_i != latched id is an assertion failure.
//  - RESP: wb_valid_o=1; outputs stable until wb_ready_i.
//    - in_ready_o = wb_ready_i: back-to-back accept. wb_ready_i & in_valid_i -> ISSUE, else -> IDLE.
//  Latency: accept at cycle T -> div_vld_o at T+1 -> wb_valid_o 1 cycle after serdiv out_vld.
//  Flush:
//  - Any state -> IDLE next cycle.
//  - Same cycle: div_vld_o, div_out_rdy_o, wb_valid_o, in_ready_o forced 0.
//  - No result is retired for the flushed op; a serdiv out_vld coincident with flush is dropped.
//  Async reset mid-operation: immediate return to reset values; serdiv is reset by the same rst_ni.
// CONFIGURATION
//  SERDIV_FRONTEND_RESULT_CACHE_EN defined:
//  - A one-entry cache holds {op, a, b, result} of the last retired op.
//  - On accept with a cache hit (valid & exact match of op and raw operands): -> RESP directly,
//    wb_valid_o at T+1, serdiv untouched.
//  - Cache is written in WAIT on capture; reset clears valid; flush does not clear it.
//  Undefined: no cache logic; every op goes through serdiv.
// TESTING
//  DIV 100/7 (op 001), wb_ready_i=1 -> wb_result 14, trans_id echoed, one div_vld_o pulse.
//  REMW a=0x00000000_FFFFFFF9 (-7), b=3 (op 111) -> wb_result 0xFFFFFFFF_FFFFFFFF (-1).
//  DIVUW a=0xFFFFFFFF_00000000, b=0 (op 100) -> div_op_a_o 0, wb_result 0xFFFFFFFF_FFFFFFFF.
//  wb_ready_i held 0 for 5 cycles in RESP -> wb_* stable; in_ready_o=0; new in_valid_i ignored.
//  flush_i in WAIT -> IDLE next cycle, no wb_valid_o; a subsequent DIVU 9/3 returns 3.
//  With cache: DIV 100/7 twice back-to-back -> second wb_valid_o at T+1, no div_vld_o pulse.

Source files
------------

// File: rtl/serdiv_frontend.sv
// Issue/retire wrapper between FU dispatch and serdiv: decodes RV64M divides, issues one request, sign-extends word results.
// Latency: accept at T -> div_vld_o at T+1 -> wb_valid_o one cycle after serdiv out_vld (T+1 on a result-cache hit).
// Backpressure: one op in flight; in_ready_o low until wb_ready_i retires the held result. Optional cache: SERDIV_FRONTEND_RESULT_CACHE_EN.
module serdiv_frontend #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TID_W = 3,
    parameter int unsigned PC_W  = 39
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  op_a_i,
    input  logic [XLEN-1:0]  op_b_i,
    input  logic [TID_W-1:0] trans_id_i,
    input  logic [PC_W-1:0]  pc_i,
    output logic             div_vld_o,
    input  logic             div_rdy_i,
    output logic [1:0]       div_opcode_o,
    output logic [XLEN-1:0]  div_op_a_o,
    output logic [XLEN-1:0]  div_op_b_o,
    output logic [TID_W-1:0] div_id_o,
    output logic [PC_W-1:0]  div_pc_o,
    output logic             div_flush_o,
    input  logic             div_out_vld_i,
    output logic             div_out_rdy_o,
    input  logic [TID_W-1:0] div_id_i,
    input  logic [XLEN-1:0]  div_res_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [TID_W-1:0] wb_trans_id_o,
    output logic [PC_W-1:0]  wb_pc_o,
    output logic [XLEN-1:0]  wb_result_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;

    // latched request: op bits and prepared operands
    logic             r_word;
    logic             r_rem;
    logic             r_signed;
    logic [XLEN-1:0]  r_op_a;
    logic [XLEN-1:0]  r_op_b;
    logic [TID_W-1:0] r_id;
    logic [PC_W-1:0]  r_pc;

    // held write-back result
    logic [TID_W-1:0] r_wb_id;
    logic [PC_W-1:0]  r_wb_pc;
    logic [XLEN-1:0]  r_wb_res;

    logic             w_accept;
    logic             w_capture;
    logic             w_hit;
    logic [XLEN-1:0]  w_cache_res;
    logic [XLEN-1:0]  w_a_prep;
    logic [XLEN-1:0]  w_b_prep;
    logic [XLEN-1:0]  w_res_ext;

    // Word ops look only at the low 32 bits; the signed flag picks sign- vs zero-extension.
    assign w_a_prep = !op_i[2] ? op_a_i :
                      op_i[0]  ? {{(XLEN-32){op_a_i[31]}}, op_a_i[31:0]} :
                                 {{(XLEN-32){1'b0}}, op_a_i[31:0]};
    assign w_b_prep = !op_i[2] ? op_b_i :
                      op_i[0]  ? {{(XLEN-32){op_b_i[31]}}, op_b_i[31:0]} :
                                 {{(XLEN-32){1'b0}}, op_b_i[31:0]};

    // serdiv computes full width; word results are re-sign-extended from bit 31, which also
    // yields the RISC-V answers for /0 and overflow without any special casing here.
    assign w_res_ext = r_word ? {{(XLEN-32){div_res_i[31]}}, div_res_i[31:0]} : div_res_i;

    // Handshake qualifiers; flush kills every handshake in the cycle it is raised.
    assign in_ready_o    = !flush_i && ((r_state == S_IDLE) || ((r_state == S_RESP) && wb_ready_i));
    assign div_vld_o     = !flush_i && (r_state == S_ISSUE) && div_rdy_i;
    assign div_out_rdy_o = !flush_i && (r_state == S_WAIT);
    assign wb_valid_o    = !flush_i && (r_state == S_RESP);
    assign div_flush_o   = flush_i;

    assign w_accept  = in_ready_o && in_valid_i;
    assign w_capture = div_out_rdy_o && div_out_vld_i;

    assign div_opcode_o  = {r_rem, r_signed};
    assign div_op_a_o    = r_op_a;
    assign div_op_b_o    = r_op_b;
    assign div_id_o      = r_id;
    assign div_pc_o      = r_pc;
    assign wb_trans_id_o = r_wb_id;
    assign wb_pc_o       = r_wb_pc;
    assign wb_result_o   = r_wb_res;

`ifdef SERDIV_FRONTEND_RESULT_CACHE_EN
    logic             r_cache_vld;
    logic [2:0]       r_cache_op;
    logic [XLEN-1:0]  r_cache_a;
    logic [XLEN-1:0]  r_cache_b;
    logic [XLEN-1:0]  r_cache_res;
    // raw operands of the in-flight op, kept so the cache tag matches what dispatch sends
    logic [XLEN-1:0]  r_raw_a;
    logic [XLEN-1:0]  r_raw_b;

    assign w_hit = r_cache_vld && (op_i == r_cache_op) &&
                   (op_a_i == r_cache_a) && (op_b_i == r_cache_b);
    assign w_cache_res = r_cache_res;

    // One-entry result cache: filled on serdiv capture, survives flush, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cache_vld <= 1'b0;
            r_cache_op  <= '0;
            r_cache_a   <= '0;
            r_cache_b   <= '0;
            r_cache_res <= '0;
            r_raw_a     <= '0;
            r_raw_b     <= '0;
        end else begin
            if (w_accept) begin
                r_raw_a <= op_a_i;
                r_raw_b <= op_b_i;
            end
            if (w_capture) begin
                r_cache_vld <= 1'b1;
                r_cache_op  <= {r_word, r_rem, r_signed};
                r_cache_a   <= r_raw_a;
                r_cache_b   <= r_raw_b;
                r_cache_res <= w_res_ext;
            end
        end
    end
`else
    assign w_hit       = 1'b0;
    assign w_cache_res = '0;
`endif

    // Control FSM: one request issued per op, result held in RESP until retired.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else if (flush_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_state <= w_hit ? S_RESP : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (div_rdy_i) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (div_out_vld_i) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (wb_ready_i) begin
                        if (in_valid_i) begin
                            r_state <= w_hit ? S_RESP : S_ISSUE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Request latch on accept and result latch on capture (or straight from the cache on a hit).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_word   <= 1'b0;
            r_rem    <= 1'b0;
            r_signed <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_id     <= '0;
            r_pc     <= '0;
            r_wb_id  <= '0;
            r_wb_pc  <= '0;
            r_wb_res <= '0;
        end else begin
            if (w_accept) begin
                r_word   <= op_i[2];
                r_rem    <= op_i[1];
                r_signed <= op_i[0];
                r_op_a   <= w_a_prep;
                r_op_b   <= w_b_prep;
                r_id     <= trans_id_i;
                r_pc     <= pc_i;
                if (w_hit) begin
                    r_wb_res <= w_cache_res;
                    r_wb_id  <= trans_id_i;
                    r_wb_pc  <= pc_i;
                end
            end
            if (w_capture) begin
                r_wb_res <= w_res_ext;
                r_wb_id  <= r_id;
                r_wb_pc  <= r_pc;
            end
        end
    end

    // serdiv must hand back the id of the op we issued; anything else means a lost or stray op.
    a_id_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_capture |-> (div_id_i == r_id));

endmodule
